// File: rtl/apb2mem_pkg.sv
// Shared types and helpers for the APB-to-mem-port bridge.
package apb2mem_pkg;

    localparam int STRB_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } apb2mem_state_e;

    // Byte i comes from new_word when strb[i] is set, otherwise from old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0]          old_word,
                                                input logic [31:0]          new_word,
                                                input logic [STRB_WIDTH-1:0] strb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb2mem_bridge.sv
// APB4 slave driving the single-cycle mem port of a generated register file.
// Adds word-alignment checking, byte-strobe handling via read-modify-write,
// registered responses and a saturating count of error responses.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for an APB access phase; latches the transfer
// RD        | single mem read, captures rdata/err
// WR        | single mem write of the full word, captures err
// RMW_RD    | mem read of the word to be partially updated, builds merge
// RMW_WR    | mem write of the merged word, captures err
// RESP      | PREADY for one cycle with captured PSLVERR/PRDATA
module apb2mem_bridge
    import apb2mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 13,
    parameter int DATA_WIDTH   = 32,
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic                    main_clk_i,
    input  logic                    main_rst_an_i,
    input  logic                    apb_psel_i,
    input  logic                    apb_penable_i,
    input  logic [ADDR_WIDTH+1:0]   apb_paddr_i,
    input  logic                    apb_pwrite_i,
    input  logic [DATA_WIDTH-1:0]   apb_pwdata_i,
    input  logic [STRB_WIDTH-1:0]   apb_pstrb_i,
    output logic [DATA_WIDTH-1:0]   apb_prdata_o,
    output logic                    apb_pready_o,
    output logic                    apb_pslverr_o,
    output logic                    mem_ena_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_wena_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_err_i,
    output logic [ERRCNT_WIDTH-1:0] errcnt_o,
    input  logic                    errcnt_clr_i
);

    // The strobe handling and merge helper assume a 32-bit bus.
    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("apb2mem_bridge: DATA_WIDTH must be 32");
    end

    apb2mem_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   strb_q, strb_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [ERRCNT_WIDTH-1:0] errcnt_q, errcnt_d;

    logic access_phase;
    logic misaligned;
    logic in_resp;

    assign access_phase = apb_psel_i & apb_penable_i;
    assign misaligned   = (apb_paddr_i[1:0] != 2'b00);
    assign in_resp      = (state_q == ST_RESP);

    // State register; a synchronous reset abandons any in-flight access.
    always_ff @(posedge main_clk_i) begin
        if (!main_rst_an_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and transfer bookkeeping (latched request, captured response).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (access_phase) begin
                    addr_d  = apb_paddr_i[ADDR_WIDTH+1:2];
                    wdata_d = apb_pwdata_i;
                    strb_d  = apb_pstrb_i;
                    write_d = apb_pwrite_i;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (!apb_pwrite_i) begin
                        state_d = ST_RD;
                    end else if (apb_pstrb_i == '1) begin
                        state_d = ST_WR;
                    end else if (apb_pstrb_i == '0) begin
                        // Write with no enabled bytes completes without touching mem.
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD: begin
                rdata_d = mem_rdata_i;
                err_d   = mem_err_i;
                state_d = ST_RESP;
            end
            ST_WR: begin
                err_d   = mem_err_i;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                // The merged word is held in wdata so the write half is driven from a register.
                rdata_d = mem_rdata_i;
                err_d   = mem_err_i;
                wdata_d = merge_bytes(mem_rdata_i, wdata_q, strb_q);
                state_d = mem_err_i ? ST_RESP : ST_RMW_WR;
            end
            ST_RMW_WR: begin
                err_d   = mem_err_i;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers for the latched request and captured response.
    always_ff @(posedge main_clk_i) begin
        if (!main_rst_an_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Error counter: clear wins over a same-cycle increment; sticks at all-ones.
    always_comb begin
        errcnt_d = errcnt_q;
        if (errcnt_clr_i) begin
            errcnt_d = '0;
        end else if (in_resp && err_q && (errcnt_q != '1)) begin
            errcnt_d = errcnt_q + 1'b1;
        end
    end

    // Error counter register.
    always_ff @(posedge main_clk_i) begin
        if (!main_rst_an_i) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    // Outputs are decoded from the state register and gated registered data only.
    assign mem_ena_o     = (state_q == ST_RD) || (state_q == ST_WR) ||
                           (state_q == ST_RMW_RD) || (state_q == ST_RMW_WR);
    assign mem_wena_o    = (state_q == ST_WR) || (state_q == ST_RMW_WR);
    assign mem_addr_o    = mem_ena_o  ? addr_q  : '0;
    assign mem_wdata_o   = mem_wena_o ? wdata_q : '0;

    assign apb_pready_o  = in_resp;
    assign apb_pslverr_o = in_resp & err_q;
    assign apb_prdata_o  = (in_resp && !write_q) ? rdata_q : '0;

    assign errcnt_o      = errcnt_q;

endmodule

// File: tb/tb_apb2mem_bridge.sv
// Self-checking bench for apb2mem_bridge: directed APB transfers against a
// small word memory, responses checked by a scoreboard monitor.
module tb_apb2mem_bridge;

    localparam int AW = 13;

    logic          clk;
    logic          rst_an;
    logic          psel;
    logic          penable;
    logic [AW+1:0] paddr;
    logic          pwrite;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;
    logic          mem_ena;
    logic [AW-1:0] mem_addr;
    logic          mem_wena;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_err;
    logic [7:0]    errcnt;
    logic          errcnt_clr;

    apb2mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .ERRCNT_WIDTH(8)) dut (
        .main_clk_i    (clk),
        .main_rst_an_i (rst_an),
        .apb_psel_i    (psel),
        .apb_penable_i (penable),
        .apb_paddr_i   (paddr),
        .apb_pwrite_i  (pwrite),
        .apb_pwdata_i  (pwdata),
        .apb_pstrb_i   (pstrb),
        .apb_prdata_o  (prdata),
        .apb_pready_o  (pready),
        .apb_pslverr_o (pslverr),
        .mem_ena_o     (mem_ena),
        .mem_addr_o    (mem_addr),
        .mem_wena_o    (mem_wena),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .mem_err_i     (mem_err),
        .errcnt_o      (errcnt),
        .errcnt_clr_i  (errcnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory; word 0x7FF (byte 0x1FFC) is unmapped and answers with err.
    logic [31:0] mem_model [0:(1<<AW)-1];
    assign mem_rdata = mem_model[mem_addr];
    assign mem_err   = mem_ena && (mem_addr == 13'h7FF);

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_model[i] = 32'h0;
        mem_model[1] = 32'h1122_3344;
        mem_model[2] = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            if (mem_ena && mem_wena && !mem_err) mem_model[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        logic [31:0] prdata;
        logic        slverr;
        int          lat;
        int          ena;
        int          wr;
        logic [12:0] waddr;
        logic [31:0] wdata;
        logic [7:0]  errcnt;
    } resp_t;

    localparam int SNAP_ZERO    = 0;
    localparam int SNAP_ERRCNT  = 1;
    localparam int SNAP_TIMEOUT = 2;
    localparam int SNAP_END     = 3;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } snap_t;

    resp_t resp_q [$];
    snap_t snap_q [$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic resp_t mk(logic [31:0] prd, logic se, int lat, int ena, int wr,
                                 logic [12:0] wa, logic [31:0] wd, logic [7:0] ec);
        resp_t r;
        r.prdata = prd; r.slverr = se; r.lat = lat; r.ena = ena; r.wr = wr;
        r.waddr = wa; r.wdata = wd; r.errcnt = ec;
        return r;
    endfunction

    // Monitor / scoreboard: the only process that compares.
    initial begin : monitor
        int          acc_cnt;
        int          ena_cnt;
        int          wr_cnt;
        logic [12:0] last_waddr;
        logic [31:0] last_wdata;
        logic        ec_pend;
        logic [7:0]  ec_exp;
        resp_t       e;
        snap_t       s;
        acc_cnt = 0; ena_cnt = 0; wr_cnt = 0;
        last_waddr = '0; last_wdata = '0;
        ec_pend = 1'b0; ec_exp = '0;
        forever begin
            @(negedge clk);
            if (ec_pend) begin
                chk("errcnt_after_resp", 32'(errcnt), 32'(ec_exp));
                ec_pend = 1'b0;
            end
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                case (s.kind)
                    SNAP_ZERO: begin
                        chk("zero_prdata",   prdata,            32'h0);
                        chk("zero_pready",   32'(pready),       32'h0);
                        chk("zero_pslverr",  32'(pslverr),      32'h0);
                        chk("zero_mem_ena",  32'(mem_ena),      32'h0);
                        chk("zero_mem_addr", 32'(mem_addr),     32'h0);
                        chk("zero_mem_wena", 32'(mem_wena),     32'h0);
                        chk("zero_mem_wdata", mem_wdata,        32'h0);
                        chk("zero_errcnt",   32'(errcnt),       32'h0);
                    end
                    SNAP_ERRCNT: chk("errcnt_snapshot", 32'(errcnt), 32'(s.val));
                    SNAP_TIMEOUT: begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL pready_timeout: no PREADY seen within cycle budget");
                        if (resp_q.size() > 0) void'(resp_q.pop_front());
                    end
                    default: chk("pending_responses", 32'(resp_q.size()), 32'h0);
                endcase
            end
            if (!rst_an) begin
                acc_cnt = 0; ena_cnt = 0; wr_cnt = 0;
            end else begin
                if (psel && penable) acc_cnt++;
                if (mem_ena) ena_cnt++;
                if (mem_ena && mem_wena) begin
                    wr_cnt++;
                    last_waddr = mem_addr;
                    last_wdata = mem_wdata;
                end
                if (pready) begin
                    if (resp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_pready: PREADY with no transfer outstanding");
                    end else begin
                        e = resp_q.pop_front();
                        chk("prdata",   prdata,          e.prdata);
                        chk("pslverr",  32'(pslverr),    32'(e.slverr));
                        chk("latency",  32'(acc_cnt),    32'(e.lat));
                        chk("mem_ena_cycles", 32'(ena_cnt), 32'(e.ena));
                        chk("mem_wr_cycles",  32'(wr_cnt),  32'(e.wr));
                        if (e.wr > 0) begin
                            chk("mem_waddr", 32'(last_waddr), 32'(e.waddr));
                            chk("mem_wdata", last_wdata,      e.wdata);
                        end
                        ec_pend = 1'b1;
                        ec_exp  = e.errcnt;
                    end
                    acc_cnt = 0; ena_cnt = 0; wr_cnt = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic xfer(input logic [AW+1:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input resp_t e);
        logic got;
        resp_q.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (pready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        if (!got) snap_q.push_back('{SNAP_TIMEOUT, 8'h0});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ec;
        rst_an = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
        pwdata = '0; pstrb = '0; errcnt_clr = 1'b0;
        ec = 0;
        repeat (3) @(posedge clk);
        #1;
        snap_q.push_back('{SNAP_ZERO, 8'h0});
        @(posedge clk); #1;
        rst_an = 1'b1;
        @(posedge clk); #1;

        // Full write then read back.
        xfer(15'h0000, 1'b1, 32'h0000_00A5, 4'hF, mk(32'h0, 1'b0, 3, 1, 1, 13'h0, 32'h0000_00A5, 8'(ec)));
        xfer(15'h0000, 1'b0, 32'h0,         4'hF, mk(32'h0000_00A5, 1'b0, 3, 1, 0, 13'h0, 32'h0, 8'(ec)));
        // Partial write of byte 1 over 0x11223344.
        xfer(15'h0004, 1'b1, 32'h0000_3C00, 4'b0010, mk(32'h0, 1'b0, 4, 2, 1, 13'h1, 32'h1122_3C44, 8'(ec)));
        xfer(15'h0004, 1'b0, 32'h0,         4'hF, mk(32'h1122_3C44, 1'b0, 3, 1, 0, 13'h0, 32'h0, 8'(ec)));
        // Misaligned read.
        ec = ec + 1;
        xfer(15'h0006, 1'b0, 32'h0,         4'hF, mk(32'h0, 1'b1, 2, 0, 0, 13'h0, 32'h0, 8'(ec)));
        // strb=0 write is a no-op; memory keeps its value.
        xfer(15'h0008, 1'b1, 32'hFFFF_FFFF, 4'h0, mk(32'h0, 1'b0, 2, 0, 0, 13'h0, 32'h0, 8'(ec)));
        xfer(15'h0008, 1'b0, 32'h0,         4'hF, mk(32'hDEAD_BEEF, 1'b0, 3, 1, 0, 13'h0, 32'h0, 8'(ec)));
        // Outer-byte partial write over zero.
        xfer(15'h000C, 1'b1, 32'hAABB_CCDD, 4'b1001, mk(32'h0, 1'b0, 4, 2, 1, 13'h3, 32'hAA00_00DD, 8'(ec)));
        xfer(15'h000C, 1'b0, 32'h0,         4'h0, mk(32'hAA00_00DD, 1'b0, 3, 1, 0, 13'h0, 32'h0, 8'(ec)));

        // RMW on the unmapped word: read half errors, write dropped; counter saturates.
        for (int i = 0; i < 300; i++) begin
            ec = (ec == 255) ? 255 : ec + 1;
            xfer(15'h1FFC, 1'b1, 32'h0000_00FF, 4'b0001, mk(32'h0, 1'b1, 3, 1, 0, 13'h0, 32'h0, 8'(ec)));
        end
        snap_q.push_back('{SNAP_ERRCNT, 8'd255});
        @(posedge clk); #1;
        errcnt_clr = 1'b1;
        @(posedge clk); #1;
        errcnt_clr = 1'b0;
        ec = 0;
        snap_q.push_back('{SNAP_ERRCNT, 8'd0});
        @(posedge clk); #1;

        // Clear held across an erroring response wins over the increment.
        errcnt_clr = 1'b1;
        xfer(15'h0001, 1'b1, 32'h1234_5678, 4'hF, mk(32'h0, 1'b1, 2, 0, 0, 13'h0, 32'h0, 8'd0));
        errcnt_clr = 1'b0;

        // Reset while the RMW read half is on the mem port.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 15'h0008; pwrite = 1'b1;
        pwdata = 32'h0000_0077; pstrb = 4'b0001;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_an = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        snap_q.push_back('{SNAP_ZERO, 8'h0});
        @(posedge clk); #1;
        rst_an = 1'b1;
        @(posedge clk); #1;
        xfer(15'h0008, 1'b0, 32'h0, 4'hF, mk(32'hDEAD_BEEF, 1'b0, 3, 1, 0, 13'h0, 32'h0, 8'd0));

        // Full write and read of the unmapped word both report an error.
        xfer(15'h1FFC, 1'b1, 32'h1234_5678, 4'hF, mk(32'h0, 1'b1, 3, 1, 1, 13'h7FF, 32'h1234_5678, 8'd1));
        xfer(15'h1FFC, 1'b0, 32'h0,         4'hF, mk(32'h0, 1'b1, 3, 1, 0, 13'h0, 32'h0, 8'd2));

        repeat (2) @(posedge clk);
        #1;
        snap_q.push_back('{SNAP_END, 8'h0});
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
